// File: rtl/state_pkg.sv
// Shared types for the state shift-register bank sequencer: lane count,
// sequencer states and lane index type.
package state_pkg;

  localparam int NUM_LANES = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ROUND  = 3'd2,
    UNLOAD = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  typedef logic [2:0] lane_idx_t;

  localparam lane_idx_t LAST_LANE = 3'd4;

endpackage

// File: rtl/seq_beat_counter.sv
// Beat-within-lane and lane counters shared by the serial load and unload
// phases; also paces the round passes (cleared at each pass end).
module seq_beat_counter
  import state_pkg::*;
#(
  parameter int BEATS = 64,
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [BW-1:0] beat,
  output lane_idx_t     lane,
  output logic          last_beat,
  output logic          last_lane
);

  assign last_beat = (beat == BW'(BEATS - 1));
  assign last_lane = (lane == LAST_LANE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
      lane <= '0;
    end else if (clear) begin
      beat <= '0;
      lane <= '0;
    end else if (inc) begin
      if (last_beat) begin
        beat <= '0;
        // lane wraps only after the final lane so it never exceeds 4
        lane <= last_lane ? 3'd0 : lane + 3'd1;
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

endmodule

// File: rtl/state_shift_sequencer.sv
// Load / round / unload controller for the 5-lane state shift-register bank;
// owns every lane enable and lane data input of the bank.
module state_shift_sequencer
  import state_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int LANE_BITS = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [3:0]                     rounds,
  output logic                           busy,
  output logic                           done,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [NUM_LANES-1:0][WIDTH-1:0] rf_data,
  input  logic [NUM_LANES-1:0]           sr_out,
  output logic [NUM_LANES-1:0]           sr_enable,
  output logic [NUM_LANES-1:0][WIDTH-1:0] sr_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_bit,
  output lane_idx_t                      out_lane,
  output logic [3:0]                     round_idx
);

  localparam int BEATS = LANE_BITS / WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  seq_state_e  state;
  logic [3:0]  rounds_latched;
  logic [3:0]  round_cnt;
  logic [BW-1:0] beat;
  lane_idx_t   lane;
  logic        last_beat;
  logic        last_lane;
  logic        cnt_clear;
  logic        cnt_inc;

  assign cnt_clear = ((state == IDLE) && start) || ((state == ROUND) && last_beat);
  assign cnt_inc   = ((state == LOAD) && in_valid) || (state == ROUND) ||
                     ((state == UNLOAD) && out_ready);

  seq_beat_counter #(.BEATS(BEATS)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .beat      (beat),
    .lane      (lane),
    .last_beat (last_beat),
    .last_lane (last_lane)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rounds_latched <= 4'd0;
      round_cnt      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rounds_latched <= rounds;
            round_cnt      <= 4'd0;
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid && last_beat && last_lane)
            state <= (rounds_latched != 4'd0) ? ROUND : UNLOAD;
        end
        ROUND: begin
          if (last_beat) begin
            if (round_cnt == rounds_latched - 4'd1) begin
              round_cnt <= 4'd0;
              state     <= UNLOAD;
            end else begin
              round_cnt <= round_cnt + 4'd1;
            end
          end
        end
        UNLOAD: begin
          if (out_ready && last_beat && last_lane) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state and counters.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sr_enable = '0;
    sr_data   = '0;
    out_lane  = 3'd0;
    round_idx = 4'd0;
    case (state)
      LOAD: begin
        busy            = 1'b1;
        in_ready        = 1'b1;
        out_lane        = lane;
        sr_enable[lane] = in_valid;
        sr_data[lane]   = in_data;
      end
      ROUND: begin
        busy      = 1'b1;
        sr_enable = '1;
        sr_data   = rf_data;
        round_idx = round_cnt;
      end
      UNLOAD: begin
        busy            = 1'b1;
        out_valid       = 1'b1;
        out_lane        = lane;
        sr_enable[lane] = out_ready;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign out_bit = sr_out[out_lane];

endmodule

// File: tb/tb_state_shift_sequencer.sv
// Bench for state_shift_sequencer driving a behavioural 5x8-bit shift bank;
// round logic feeds back the inverted lane MSB.
module tb_state_shift_sequencer;

  localparam int W  = 1;
  localparam int LB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        rounds;
  logic              busy, done;
  logic              in_valid, in_ready;
  logic [W-1:0]      in_data;
  logic [4:0][W-1:0] rf_data;
  logic [4:0]        sr_out;
  logic [4:0]        sr_enable;
  logic [4:0][W-1:0] sr_data;
  logic              out_valid, out_ready, out_bit;
  logic [2:0]        out_lane;
  logic [3:0]        round_idx;

  logic [LB-1:0] bank [5] = '{default: '0};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  state_shift_sequencer #(.WIDTH(W), .LANE_BITS(LB)) dut (
    .clk(clk), .rst(rst), .start(start), .rounds(rounds), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rf_data(rf_data),
    .sr_out(sr_out), .sr_enable(sr_enable), .sr_data(sr_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_bit(out_bit), .out_lane(out_lane), .round_idx(round_idx)
  );

  // Shift-register bank: MSB is the serial output, new bits enter at the LSB.
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (sr_enable[i]) bank[i] <= {bank[i][LB-2:0], sr_data[i]};
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      sr_out[i]  = bank[i][LB-1];
      rf_data[i] = ~bank[i][LB-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_sr_enable"}, sr_enable, 5'd0);
    check({tag, "_sr_data"}, sr_data, 5'd0);
    check({tag, "_out_lane"}, out_lane, 3'd0);
    check({tag, "_round_idx"}, round_idx, 4'd0);
  endtask

  // vmode/rmode: 0 = always on, 1 = toggle valid / 5-cycle stall at lane 3 beat 4, 2 = random
  task automatic run_seq(input logic [39:0] d, input logic [3:0] nr, input int vmode,
                         input int rmode, input int exp_done, input bit poke);
    int li = 0, ui = 0, rc = 0, stall = 0, done_cyc = 0, last_out = 0;
    bit got_done = 1'b0;
    logic [39:0] e;
    e = nr[0] ? ~d : d;
    for (int cyc = 1; cyc <= 3000 && !got_done; cyc++) begin
      @(negedge clk);
      start  = (cyc == 1);
      rounds = nr;
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = (li < 40) ? d[39 - li] : 1'b0;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(ui == 28 && stall < 5);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (in_ready) begin
        check("ld_lane", out_lane, 32'(li / 8));
        check("ld_en", sr_enable, in_valid ? (5'd1 << (li / 8)) : 5'd0);
        if (in_valid) begin
          check("ld_data", sr_data, 5'(in_data) << (li / 8));
          li++;
        end
      end
      if (out_valid) begin
        check("ul_lane", out_lane, 32'(ui / 8));
        check("ul_bit", out_bit, e[39 - ui]);
        check("ul_en", sr_enable, out_ready ? (5'd1 << (ui / 8)) : 5'd0);
        check("ul_data", sr_data, 5'd0);
        if (out_ready) begin
          ui++;
          last_out = cyc;
        end else begin
          stall++;
        end
      end
      if (busy && !in_ready && !out_valid && !done) begin
        check("rnd_idx", round_idx, 32'(rc / 8));
        check("rnd_en", sr_enable, 5'h1f);
        check("rnd_data", sr_data, rf_data);
        rc++;
        if (poke) start = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        check("done_busy", busy, 1'b1);
        if (poke) start = 1'b1;
      end
    end
    check("got_done", got_done, 1'b1);
    check("load_beats", li, 40);
    check("unload_beats", ui, 40);
    check("round_cycles", rc, 32'(8 * nr));
    check("done_after_unload", done_cyc, last_out + 1);
    if (exp_done > 0) check("done_cycle", done_cyc, exp_done);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check_idle("post");
    end
  endtask

  typedef struct {
    logic [39:0] d;
    logic [3:0]  nr;
    int          vmode;
    int          rmode;
    int          exp_done;
    bit          poke;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [63:0] r64;
    tbl[0] = '{40'hA53CFF0081, 4'd0,  0, 0, 82,  1'b0};
    tbl[1] = '{40'hA53CFF0081, 4'd2,  0, 0, 98,  1'b0};
    tbl[2] = '{40'h0123456789, 4'd1,  1, 0, 129, 1'b0};
    tbl[3] = '{40'hDEADBEEF55, 4'd3,  0, 1, 111, 1'b1};
    tbl[4] = '{40'hFFFFFFFFFF, 4'd15, 0, 0, 202, 1'b0};

    rst = 1'b1; start = 1'b0; rounds = 4'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Abort mid-load at lane 2 beat 3.
    start = 1'b1; rounds = 4'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 1'b1;
    repeat (19) @(negedge clk);
    check("abort_lane", out_lane, 3'd2);
    #1 rst = 1'b1;
    #1;
    check_idle("abort");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_idle("abort_idle");

    for (int t = 0; t < 5; t++)
      run_seq(tbl[t].d, tbl[t].nr, tbl[t].vmode, tbl[t].rmode, tbl[t].exp_done, tbl[t].poke);

    for (int t = 0; t < 6; t++) begin
      r64 = {$urandom, $urandom};
      run_seq(r64[39:0], 4'($urandom_range(0, 3)), 2, 2, -1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
